// File: rtl/dsi_rsp_pkg.sv
// Shared definitions for the DSI read-back responder.
// Holds the MIPI data-type codes used on the RX and TX command ports, the
// acknowledge-and-error-report payload, the responder state encoding and the
// helper that picks the response data type from the read type and byte count.
package dsi_rsp_pkg;

  localparam logic [5:0] DT_DCS_READ    = 6'h06;
  localparam logic [5:0] DT_GEN_READ    = 6'h14;
  localparam logic [5:0] DT_DCS_SHORT1  = 6'h21;
  localparam logic [5:0] DT_DCS_SHORT2  = 6'h22;
  localparam logic [5:0] DT_DCS_LONG    = 6'h1C;
  localparam logic [5:0] DT_GEN_SHORT1  = 6'h11;
  localparam logic [5:0] DT_GEN_SHORT2  = 6'h12;
  localparam logic [5:0] DT_GEN_LONG    = 6'h1A;
  localparam logic [5:0] DT_ACK_ERR     = 6'h02;

  localparam int unsigned ERR_BIT    = 11;
  localparam logic [15:0] ERR_REPORT = 16'(1) << ERR_BIT;

  typedef enum logic [1:0] {IDLE, ARMED, REQ, PAYLOAD} state_t;

  function automatic logic [5:0] rsp_type(input logic dcs, input logic [15:0] cnt);
    if (cnt == 16'd1)      return dcs ? DT_DCS_SHORT1 : DT_GEN_SHORT1;
    else if (cnt == 16'd2) return dcs ? DT_DCS_SHORT2 : DT_GEN_SHORT2;
    else                   return dcs ? DT_DCS_LONG   : DT_GEN_LONG;
  endfunction

endpackage

// File: rtl/dsi_rsp_table.sv
// Runtime-loadable response table.
// Ports: wr_* = host write port (header or payload word), match_cmd = command
// to look up, hit/hit_entry/hit_cnt = lowest-index valid match (combinational),
// rd_entry/rd_word/rd_data = asynchronous payload word read.
module dsi_rsp_table
  import dsi_rsp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned MAX_WORDS   = 16,
  parameter int unsigned EW          = 3,
  parameter int unsigned WW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [EW-1:0] wr_entry,
  input  logic [WW-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic [15:0]   match_cmd,
  output logic          hit,
  output logic [EW-1:0] hit_entry,
  output logic [15:0]   hit_cnt,
  input  logic [EW-1:0] rd_entry,
  input  logic [WW-1:0] rd_word,
  output logic [31:0]   rd_data
);

  localparam logic [15:0] CNT_MAX = 16'(MAX_WORDS * 4);

  logic [NUM_ENTRIES-1:0] valid;
  logic [15:0]            hdr_cmd [NUM_ENTRIES];
  logic [15:0]            hdr_cnt [NUM_ENTRIES];
  logic [31:0]            mem     [NUM_ENTRIES][MAX_WORDS];

  logic entry_ok;
  logic word_ok;
  assign entry_ok = 32'(wr_entry) < NUM_ENTRIES;
  assign word_ok  = 32'(wr_word) < MAX_WORDS;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en && !wr_sel && entry_ok) begin
      valid[wr_entry] <= wr_data[15:0] != 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en && entry_ok) begin
      if (!wr_sel) begin
        hdr_cmd[wr_entry] <= wr_data[31:16];
        hdr_cnt[wr_entry] <= (wr_data[15:0] > CNT_MAX) ? CNT_MAX : wr_data[15:0];
      end else if (word_ok) begin
        mem[wr_entry][wr_word] <= wr_data;
      end
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_entry = '0;
    hit_cnt   = '0;
    for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
      if (valid[i-1] && hdr_cmd[i-1] == match_cmd) begin
        hit       = 1'b1;
        hit_entry = EW'(i - 1);
        hit_cnt   = hdr_cnt[i-1];
      end
    end
  end

  assign rd_data = mem[rd_entry][rd_word];

endmodule

// File: rtl/dsi_read_responder.sv
// DSI peripheral read-back responder (clk_periph domain).
// Decodes DCS/generic reads from the RX command port, looks them up in the
// host-loaded response table, and after bus turnaround (falling direction)
// requests a TX header and streams the payload words first-word-fall-through.
// Ports: mipi_periph_rx_* = RX header in; mipi_periph_dphy_direction = bus
// turnaround; mipi_periph_tx_* = TX header/payload handshake; cfg_* = table
// load port (IDLE only); busy/stat_* = status with stat_clr.
module dsi_read_responder
  import dsi_rsp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned MAX_WORDS   = 16,
  parameter logic [1:0]  VC          = 2'd0,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic        clk_periph,
  input  logic        rst,
  input  logic [23:0] mipi_periph_rx_cmd,
  input  logic        mipi_periph_rx_cmd_valid,
  input  logic        mipi_periph_dphy_direction,
  input  logic        mipi_periph_tx_cmd_ack,
  input  logic        mipi_periph_tx_payload_en,
  input  logic        mipi_periph_tx_payload_en_last,
  output logic [31:0] mipi_periph_tx_payload,
  output logic [1:0]  mipi_periph_tx_cmd_vc,
  output logic [5:0]  mipi_periph_tx_cmd_data_type,
  output logic [15:0] mipi_periph_tx_cmd_byte_count,
  output logic        mipi_periph_tx_cmd_req,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [(NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1)-1:0] cfg_entry,
  input  logic [(MAX_WORDS > 1 ? $clog2(MAX_WORDS) : 1)-1:0]     cfg_word,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ready,
  output logic        busy,
  output logic        stat_overrun,
  output logic        stat_timeout,
  input  logic        stat_clr
);

  localparam int unsigned EW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned WW = MAX_WORDS > 1 ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned IW = $clog2(MAX_WORDS + 1);
  localparam int unsigned TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;

  state_t          state;
  logic            dir_q, dir_fall_q;
  logic [5:0]      rsp_dt;
  logic [15:0]     rsp_cnt;
  logic            rsp_hit, rsp_long;
  logic [EW-1:0]   rsp_entry;
  logic [IW-1:0]   rsp_words, widx;
  logic [TW-1:0]   tcnt;

  logic [5:0]      rx_dt;
  logic            rx_is_read, accept;
  logic            hit;
  logic [EW-1:0]   hit_entry;
  logic [15:0]     hit_cnt;
  logic [5:0]      new_dt, eff_dt;
  logic [15:0]     new_cnt, eff_cnt;
  logic            new_long, eff_long, eff_hit;
  logic [IW-1:0]   new_words, nxt_idx;
  logic [EW-1:0]   eff_entry, rd_entry;
  logic [WW-1:0]   rd_word;
  logic [31:0]     rd_data, nxt_data;

  assign rx_dt                 = mipi_periph_rx_cmd[5:0];
  assign mipi_periph_tx_cmd_vc = VC;
  assign cfg_ready             = state == IDLE;
  assign busy                  = state != IDLE;

  dsi_rsp_table #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .MAX_WORDS  (MAX_WORDS),
    .EW         (EW),
    .WW         (WW)
  ) u_table (
    .clk      (clk_periph),
    .rst      (rst),
    .wr_en    (cfg_we && cfg_ready),
    .wr_sel   (cfg_sel),
    .wr_entry (cfg_entry),
    .wr_word  (cfg_word),
    .wr_data  (cfg_wdata),
    .match_cmd(mipi_periph_rx_cmd[23:8]),
    .hit      (hit),
    .hit_entry(hit_entry),
    .hit_cnt  (hit_cnt),
    .rd_entry (rd_entry),
    .rd_word  (rd_word),
    .rd_data  (rd_data)
  );

  // eff_* is the response that will be sent if the turnaround lands now: a read
  // in the same cycle as the turnaround edge still wins over the latched one.
  always_comb begin
    rx_is_read = mipi_periph_rx_cmd_valid && (rx_dt == DT_DCS_READ || rx_dt == DT_GEN_READ);
    accept     = rx_is_read && (state == IDLE || state == ARMED ||
                 (state == PAYLOAD && mipi_periph_tx_payload_en_last));
    if (hit) begin
      new_dt   = rsp_type(rx_dt == DT_DCS_READ, hit_cnt);
      new_cnt  = hit_cnt;
      new_long = hit_cnt > 16'd2;
    end else begin
      new_dt   = DT_ACK_ERR;
      new_cnt  = ERR_REPORT;
      new_long = 1'b0;
    end
    new_words = IW'((hit_cnt + 16'd3) >> 2);
    eff_dt    = accept ? new_dt    : rsp_dt;
    eff_cnt   = accept ? new_cnt   : rsp_cnt;
    eff_long  = accept ? new_long  : rsp_long;
    eff_hit   = accept ? hit       : rsp_hit;
    eff_entry = accept ? hit_entry : rsp_entry;
    nxt_idx   = (widx == IW'(MAX_WORDS)) ? widx : widx + 1'b1;
    rd_entry  = (state == PAYLOAD) ? rsp_entry : eff_entry;
    rd_word   = (state == PAYLOAD) ? nxt_idx[WW-1:0] : '0;
    nxt_data  = (nxt_idx < rsp_words) ? rd_data : '0;
  end

  always_ff @(posedge clk_periph) begin
    if (rst) begin
      state                         <= IDLE;
      dir_q                         <= 1'b0;
      dir_fall_q                    <= 1'b0;
      rsp_dt                        <= '0;
      rsp_cnt                       <= '0;
      rsp_hit                       <= 1'b0;
      rsp_long                      <= 1'b0;
      rsp_entry                     <= '0;
      rsp_words                     <= '0;
      widx                          <= '0;
      tcnt                          <= '0;
      mipi_periph_tx_payload        <= '0;
      mipi_periph_tx_cmd_data_type  <= '0;
      mipi_periph_tx_cmd_byte_count <= '0;
      mipi_periph_tx_cmd_req        <= 1'b0;
      stat_overrun                  <= 1'b0;
      stat_timeout                  <= 1'b0;
    end else begin
      dir_q      <= mipi_periph_dphy_direction;
      dir_fall_q <= dir_q && !mipi_periph_dphy_direction;

      if (stat_clr) begin
        stat_overrun <= 1'b0;
        stat_timeout <= 1'b0;
      end

      if (accept) begin
        rsp_dt    <= new_dt;
        rsp_cnt   <= new_cnt;
        rsp_hit   <= hit;
        rsp_long  <= new_long;
        rsp_entry <= hit_entry;
        rsp_words <= new_words;
      end

      case (state)
        IDLE: begin
          if (accept) state <= ARMED;
        end
        ARMED: begin
          if (dir_fall_q) begin
            state                         <= REQ;
            mipi_periph_tx_cmd_req        <= 1'b1;
            tcnt                          <= '0;
            widx                          <= '0;
            mipi_periph_tx_cmd_data_type  <= eff_dt;
            mipi_periph_tx_cmd_byte_count <= (eff_hit && !eff_long) ? rd_data[15:0] : eff_cnt;
            mipi_periph_tx_payload        <= eff_hit ? rd_data : '0;
          end
        end
        REQ: begin
          if (rx_is_read) stat_overrun <= 1'b1;
          if (mipi_periph_tx_cmd_ack) begin
            mipi_periph_tx_cmd_req <= 1'b0;
            if (rsp_long) begin
              state <= PAYLOAD;
            end else begin
              state                         <= IDLE;
              mipi_periph_tx_payload        <= '0;
              mipi_periph_tx_cmd_data_type  <= '0;
              mipi_periph_tx_cmd_byte_count <= '0;
            end
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            state                         <= IDLE;
            mipi_periph_tx_cmd_req        <= 1'b0;
            stat_timeout                  <= 1'b1;
            mipi_periph_tx_payload        <= '0;
            mipi_periph_tx_cmd_data_type  <= '0;
            mipi_periph_tx_cmd_byte_count <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        PAYLOAD: begin
          if (mipi_periph_tx_payload_en_last) begin
            state                         <= accept ? ARMED : IDLE;
            mipi_periph_tx_payload        <= '0;
            mipi_periph_tx_cmd_data_type  <= '0;
            mipi_periph_tx_cmd_byte_count <= '0;
          end else begin
            if (rx_is_read) stat_overrun <= 1'b1;
            if (mipi_periph_tx_payload_en) begin
              widx                   <= nxt_idx;
              mipi_periph_tx_payload <= nxt_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_read_responder.sv
// Self-checking bench for dsi_read_responder: loads a response table, runs a
// vector table of reads through a header/payload scoreboard, then exercises
// timeout, overrun, coincident reads, busy config writes and mid-request reset.
module tb_dsi_read_responder;
  localparam int unsigned NE  = 8;
  localparam int unsigned MW  = 16;
  localparam int unsigned AT  = 64;
  localparam logic [1:0]  TVC = 2'd2;

  logic        clk_periph = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rx_cmd = '0;
  logic        rx_valid = 1'b0, direction = 1'b0, ack = 1'b0, en = 1'b0, last = 1'b0;
  logic [31:0] tx_payload;
  logic [1:0]  tx_vc;
  logic [5:0]  tx_dt;
  logic [15:0] tx_bc;
  logic        tx_req;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [2:0]  cfg_entry = '0;
  logic [3:0]  cfg_word = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_ready, busy, stat_overrun, stat_timeout;
  logic        stat_clr = 1'b0;

  always #5 clk_periph = ~clk_periph;

  dsi_read_responder #(
    .NUM_ENTRIES(NE),
    .MAX_WORDS  (MW),
    .VC         (TVC),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk_periph                    (clk_periph),
    .rst                           (rst),
    .mipi_periph_rx_cmd            (rx_cmd),
    .mipi_periph_rx_cmd_valid      (rx_valid),
    .mipi_periph_dphy_direction    (direction),
    .mipi_periph_tx_cmd_ack        (ack),
    .mipi_periph_tx_payload_en     (en),
    .mipi_periph_tx_payload_en_last(last),
    .mipi_periph_tx_payload        (tx_payload),
    .mipi_periph_tx_cmd_vc         (tx_vc),
    .mipi_periph_tx_cmd_data_type  (tx_dt),
    .mipi_periph_tx_cmd_byte_count (tx_bc),
    .mipi_periph_tx_cmd_req        (tx_req),
    .cfg_we                        (cfg_we),
    .cfg_sel                       (cfg_sel),
    .cfg_entry                     (cfg_entry),
    .cfg_word                      (cfg_word),
    .cfg_wdata                     (cfg_wdata),
    .cfg_ready                     (cfg_ready),
    .busy                          (busy),
    .stat_overrun                  (stat_overrun),
    .stat_timeout                  (stat_timeout),
    .stat_clr                      (stat_clr)
  );

  int checks = 0;
  int errors = 0;
  logic [21:0] hdr_q[$];
  logic [31:0] word_q[$];
  logic [31:0] mw [NE][MW];

  typedef struct {
    logic [23:0] cmd;
    logic [5:0]  dt;
    logic [15:0] bc;
    bit          lng;
    int          n_en;
    int          ent;
    int          nwords;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input bit sel, input int entry, input int word, input logic [31:0] data, input bit rec);
    cfg_we = 1'b1; cfg_sel = sel; cfg_entry = 3'(entry); cfg_word = 4'(word); cfg_wdata = data;
    @(negedge clk_periph);
    cfg_we = 1'b0;
    if (rec && sel) mw[entry][word] = data;
  endtask

  task automatic send_read(input logic [23:0] cmd);
    rx_cmd = cmd; rx_valid = 1'b1;
    @(negedge clk_periph);
    rx_valid = 1'b0; rx_cmd = '0;
  endtask

  task automatic turnaround();
    direction = 1'b1;
    @(negedge clk_periph);
    direction = 1'b0;
    @(negedge clk_periph);
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!tx_req && lat < 20) begin
      @(negedge clk_periph);
      lat++;
    end
    chk("req_seen", 32'(tx_req), 32'd1);
  endtask

  task automatic push_exp(input vec_t v);
    hdr_q.push_back({v.dt, v.bc});
    if (v.lng)
      for (int j = 0; j < v.n_en; j++)
        word_q.push_back(j < v.nwords ? mw[v.ent][j] : 32'h0);
  endtask

  // Called with req visible: checks header, acks, drains payload through the scoreboard.
  task automatic finish_resp(input bit lng, input int n_en);
    logic [21:0] h;
    logic [31:0] w;
    if (hdr_q.size() == 0) begin
      chk("hdr_queue_empty", 32'd0, 32'd1);
      h = '0;
    end else h = hdr_q.pop_front();
    chk("hdr_dt", 32'(tx_dt), 32'(h[21:16]));
    chk("hdr_bc", 32'(tx_bc), 32'(h[15:0]));
    ack = 1'b1;
    @(negedge clk_periph);
    ack = 1'b0;
    chk("req_drop_after_ack", 32'(tx_req), 32'd0);
    if (lng) begin
      for (int j = 0; j < n_en; j++) begin
        if (word_q.size() == 0) begin
          chk("word_queue_empty", 32'd0, 32'd1);
          w = '0;
        end else w = word_q.pop_front();
        chk($sformatf("payload_w%0d", j), tx_payload, w);
        en = 1'b1; last = (j == n_en - 1);
        @(negedge clk_periph);
      end
      en = 1'b0; last = 1'b0;
    end
    chk("payload_zero_idle", tx_payload, 32'h0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    push_exp(v);
    send_read(v.cmd);
    turnaround();
    wait_req(lat);
    chk("req_latency", 32'(lat), 32'd1);
    finish_resp(v.lng, v.n_en);
  endtask

  initial begin
    int lat;
    int cnt;
    vec_t miss;

    for (int e = 0; e < NE; e++)
      for (int k = 0; k < MW; k++) mw[e][k] = '0;

    //          cmd         dt     bc        lng  n_en ent nwords
    vecs[0] = '{24'h00DA06, 6'h1C, 16'h0004, 1'b1, 1,  0, 1};
    vecs[1] = '{24'h000A14, 6'h11, 16'h009C, 1'b0, 0,  1, 1};
    vecs[2] = '{24'h00EE06, 6'h02, 16'h0800, 1'b0, 0,  0, 0};
    vecs[3] = '{24'h00B706, 6'h1C, 16'h0040, 1'b1, 18, 2, 16};
    vecs[4] = '{24'h005506, 6'h22, 16'h1234, 1'b0, 0,  3, 1};
    vecs[5] = '{24'h006614, 6'h1A, 16'h0006, 1'b1, 3,  5, 2};
    vecs[6] = '{24'h007706, 6'h02, 16'h0800, 1'b0, 0,  0, 0};
    vecs[7] = '{24'h00DA14, 6'h1A, 16'h0004, 1'b1, 1,  0, 1};
    vecs[8] = '{24'h000A06, 6'h21, 16'h009C, 1'b0, 0,  1, 1};
    vecs[9] = '{24'h005514, 6'h12, 16'h1234, 1'b0, 0,  3, 1};

    repeat (3) @(negedge clk_periph);
    rst = 1'b0;
    @(negedge clk_periph);
    chk("rst_req", 32'(tx_req), 32'd0);
    chk("rst_vc", 32'(tx_vc), 32'(TVC));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_payload", tx_payload, 32'h0);
    chk("rst_dt_bc", {10'h0, tx_dt, tx_bc}, 32'h0);
    chk("rst_stats", {30'h0, stat_overrun, stat_timeout}, 32'h0);

    cfg_write(1'b0, 0, 0, {16'h00DA, 16'd4}, 1'b1);
    cfg_write(1'b1, 0, 0, 32'h44332211, 1'b1);
    cfg_write(1'b0, 1, 0, {16'h000A, 16'd1}, 1'b1);
    cfg_write(1'b1, 1, 0, 32'h0000009C, 1'b1);
    cfg_write(1'b0, 2, 0, {16'h00B7, 16'd147}, 1'b1);
    for (int k = 0; k < MW; k++) cfg_write(1'b1, 2, k, 32'hB7000000 | 32'(k * 3 + 1), 1'b1);
    cfg_write(1'b0, 3, 0, {16'h0055, 16'd2}, 1'b1);
    cfg_write(1'b1, 3, 0, 32'hAAAA1234, 1'b1);
    cfg_write(1'b0, 4, 0, {16'h00DA, 16'd8}, 1'b1);
    cfg_write(1'b1, 4, 0, 32'hDEADBEEF, 1'b1);
    cfg_write(1'b0, 5, 0, {16'h0066, 16'd6}, 1'b1);
    cfg_write(1'b1, 5, 0, 32'h11112222, 1'b1);
    cfg_write(1'b1, 5, 1, 32'h33334444, 1'b1);
    cfg_write(1'b0, 6, 0, {16'h0077, 16'd4}, 1'b1);
    cfg_write(1'b0, 6, 0, {16'h0077, 16'd0}, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Non-read data type: no response.
    send_read(24'h00DA05);
    turnaround();
    repeat (3) @(negedge clk_periph);
    chk("ignored_dt_req", 32'(tx_req), 32'd0);
    chk("ignored_dt_busy", 32'(busy), 32'd0);

    // Ack never arrives.
    send_read(24'h00DA06);
    turnaround();
    wait_req(lat);
    cnt = 0;
    while (tx_req && cnt < int'(AT) + 10) begin
      @(negedge clk_periph);
      cnt++;
    end
    chk("timeout_req_cycles", 32'(cnt), 32'(AT));
    chk("timeout_flag", 32'(stat_timeout), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    stat_clr = 1'b1;
    @(negedge clk_periph);
    stat_clr = 1'b0;
    chk("timeout_cleared", 32'(stat_timeout), 32'd0);

    // Read during PAYLOAD is dropped and flagged.
    send_read(24'h00B706);
    turnaround();
    wait_req(lat);
    ack = 1'b1;
    @(negedge clk_periph);
    ack = 1'b0;
    chk("overrun_before", 32'(stat_overrun), 32'd0);
    send_read(24'h000A14);
    chk("overrun_set", 32'(stat_overrun), 32'd1);
    chk("overrun_payload_held", tx_payload, mw[2][0]);
    en = 1'b1; last = 1'b1;
    @(negedge clk_periph);
    en = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk_periph);
    chk("overrun_read_dropped", 32'(busy), 32'd0);
    stat_clr = 1'b1;
    @(negedge clk_periph);
    stat_clr = 1'b0;
    chk("overrun_cleared", 32'(stat_overrun), 32'd0);

    // Read coincident with the last payload word is accepted.
    send_read(24'h00DA06);
    turnaround();
    wait_req(lat);
    ack = 1'b1;
    @(negedge clk_periph);
    ack = 1'b0;
    en = 1'b1; last = 1'b1; rx_cmd = 24'h000A14; rx_valid = 1'b1;
    @(negedge clk_periph);
    en = 1'b0; last = 1'b0; rx_valid = 1'b0; rx_cmd = '0;
    chk("coincident_armed", 32'(busy), 32'd1);
    chk("coincident_no_overrun", 32'(stat_overrun), 32'd0);
    hdr_q.push_back({6'h11, 16'h009C});
    turnaround();
    wait_req(lat);
    finish_resp(1'b0, 0);

    // Latest read wins in ARMED; config writes while busy are dropped.
    hdr_q.push_back({6'h02, 16'h0800});
    send_read(24'h000A14);
    send_read(24'h00EE06);
    chk("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_write(1'b0, 1, 0, {16'h000A, 16'd0}, 1'b0);
    cfg_write(1'b1, 0, 0, 32'hCAFEF00D, 1'b0);
    turnaround();
    wait_req(lat);
    finish_resp(1'b0, 0);
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    // Reset while the request is up.
    send_read(24'h00DA06);
    turnaround();
    wait_req(lat);
    rst = 1'b1;
    @(negedge clk_periph);
    rst = 1'b0;
    chk("rst_mid_req", 32'(tx_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_payload", tx_payload, 32'h0);
    chk("rst_mid_dt", 32'(tx_dt), 32'd0);
    miss = '{24'h00DA06, 6'h02, 16'h0800, 1'b0, 0, 0, 0};
    run_vec(miss);

    chk("scoreboard_drained", 32'(hdr_q.size() + word_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
